// File: rtl/htif_in_arbiter.sv
// htif_in_arbiter
//   Packet-level arbiter for the single HTIF input channel into Top. Two
//   requesters share the channel:
//   - the host, with valid/ready/last handshaking;
//   - the mem-backup narrow responses, which have no backpressure.
//   Backup words are buffered in an internal FIFO. A backup packet is only
//   granted once it is fully buffered. Packets never interleave, so a host
//   packet is never broken up by backup traffic.
//
// Ports
//   htif_clk       clock, all state on posedge
//   reset          synchronous, active-high
//   host_in_*      host word stream (valid/ready/bits/last)
//   bk_in_*        backup response words (valid/bits), cannot be stalled
//   out_*          word stream to Top io_host_in (valid/ready/bits)
//   fifo_count     backup words currently buffered
//   grant          00 idle, 01 host, 10 backup (mirrors the FSM state)
//   overflow       sticky flag, a backup word arrived while the FIFO was full
module htif_in_arbiter #(
   parameter int WIDTH        = 16,
   parameter int FIFO_DEPTH   = 32,
   parameter int BK_PKT_WORDS = 8,
   parameter int HI_WATER     = 24
) (
   input  logic                          htif_clk,
   input  logic                          reset,
   input  logic                          host_in_valid,
   output logic                          host_in_ready,
   input  logic [WIDTH-1:0]              host_in_bits,
   input  logic                          host_in_last,
   input  logic                          bk_in_valid,
   input  logic [WIDTH-1:0]              bk_in_bits,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [WIDTH-1:0]              out_bits,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic [1:0]                    grant,
   output logic                          overflow
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int WC_W  = $clog2(BK_PKT_WORDS + 1);

   localparam logic [CNT_W-1:0] PKT_CNT   = CNT_W'(BK_PKT_WORDS);
   localparam logic [CNT_W-1:0] HI_CNT    = CNT_W'(HI_WATER);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
   localparam logic [WC_W-1:0]  WC_LAST   = WC_W'(BK_PKT_WORDS - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_HOST = 2'b01,
      ST_BKUP = 2'b10
   } state_t;

   state_t             state_q, state_d;
   logic               last_bk_q, last_bk_d;     // last grant went to backup
   logic [WC_W-1:0]    wcnt_q, wcnt_d;           // words sent in current backup packet
   logic [CNT_W-1:0]   count_q, count_d;
   logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic               overflow_q, overflow_d;
   logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];

   logic               push;
   logic               pop;
   logic               full;
   logic               cand_b;
   logic               hi_water;

   // Arbitration FSM: next state and channel outputs.
   always_comb begin
      // NOTE: every signal assigned in this block gets a default first, so no latches are inferred.
      state_d       = state_q;
      last_bk_d     = last_bk_q;
      wcnt_d        = wcnt_q;
      out_valid     = 1'b0;
      out_bits      = '0;
      host_in_ready = 1'b0;
      pop           = 1'b0;
      cand_b        = (count_q >= PKT_CNT);
      hi_water      = (count_q >= HI_CNT);

      unique case (state_q)
         ST_IDLE: begin
            if (cand_b && hi_water) begin
               state_d   = ST_BKUP;
               last_bk_d = 1'b1;
            end else if (host_in_valid && cand_b) begin
               // Round-robin: the side that did not win last time goes now.
               state_d   = last_bk_q ? ST_HOST : ST_BKUP;
               last_bk_d = ~last_bk_q;
            end else if (host_in_valid) begin
               state_d   = ST_HOST;
               last_bk_d = 1'b0;
            end else if (cand_b) begin
               state_d   = ST_BKUP;
               last_bk_d = 1'b1;
            end
         end
         ST_HOST: begin
            out_valid     = host_in_valid;
            out_bits      = host_in_valid ? host_in_bits : '0;
            host_in_ready = out_ready;
            if (host_in_valid && out_ready && host_in_last) begin
               state_d = ST_IDLE;
            end
         end
         ST_BKUP: begin
            out_valid = 1'b1;
            out_bits  = mem_q[rd_ptr_q];
            if (out_ready) begin
               pop = 1'b1;
               if (wcnt_q == WC_LAST) begin
                  wcnt_d  = '0;
                  state_d = ST_IDLE;
               end else begin
                  wcnt_d = wcnt_q + 1'b1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // The reset is synchronous, so the state register still holds its old
      // value during the reset cycle. Force the channel quiet while it is asserted.
      if (reset) begin
         out_valid     = 1'b0;
         out_bits      = '0;
         host_in_ready = 1'b0;
         pop           = 1'b0;
      end
   end

   // Backup FIFO bookkeeping. A push into a full FIFO is allowed only
   // when a pop frees a slot in the same cycle.
   always_comb begin
      full       = (count_q == FULL_CNT);
      push       = bk_in_valid && !reset && (!full || pop);
      wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d   = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_d    = count_q;
      if (push && !pop) begin
         count_d = count_q + 1'b1;
      end else if (pop && !push) begin
         count_d = count_q - 1'b1;
      end
      overflow_d = overflow_q | (bk_in_valid && full && !pop);
   end

   always_ff @(posedge htif_clk) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      if (reset) begin
         state_q    <= ST_IDLE;
         last_bk_q  <= 1'b1;
         wcnt_q     <= '0;
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         last_bk_q  <= last_bk_d;
         wcnt_q     <= wcnt_d;
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   // NOTE: FIFO storage is not reset; the pointers and count decide which entries are meaningful.
   always_ff @(posedge htif_clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= bk_in_bits;
      end
   end

   assign fifo_count = count_q;
   assign grant      = reset ? ST_IDLE : state_q;
   assign overflow   = overflow_q;

endmodule
